// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and encodings for the memory port arbiter.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: counts cycles since issue, done when MEM_LAT is reached.
module mem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_load,
  input  logic i_inc,
  output logic o_done
);
  localparam int W = $clog2(MEM_LAT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge Clk) begin
    if (Reset) r_cnt <= '0;
    else if (i_load) r_cnt <= W'(1);
    else if (i_inc) r_cnt <= r_cnt + W'(1);
  end
  assign o_done = r_cnt == W'(MEM_LAT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data requesters.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t r_state, w_next;
  owner_t r_owner;
  logic [SW-1:0] r_starve;
  logic w_starved, w_grant_if, w_grant_d, w_lat_done;
  assign w_starved = r_starve == SW'(STARVE_MAX);
  assign w_grant_if = r_state == IDLE && if_req && (!d_req || w_starved);
  assign w_grant_d = r_state == IDLE && d_req && !w_grant_if;
  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .Clk(Clk),
    .Reset(Reset),
    .i_load(r_state == ISSUE),
    .i_inc(r_state == WAIT && !w_lat_done),
    .o_done(w_lat_done)
  );
  always_comb begin
    w_next = r_state == IDLE  ? ((w_grant_if || w_grant_d) ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? (w_lat_done ? RESP : WAIT) : IDLE;
  end
  // Starvation saturates implicitly: a starved fetch always wins, so data cannot grant past STARVE_MAX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
      r_starve <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      mem_rw <= RW_READ;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_size <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_if) begin
        r_owner <= OWN_IF;
        mem_rw <= RW_READ;
        mem_addr <= if_addr;
        mem_size <= SIZE_WORD;
        r_starve <= '0;
      end else if (w_grant_d) begin
        r_owner <= OWN_D;
        mem_rw <= d_rw;
        mem_addr <= d_addr;
        mem_wdata <= d_wdata;
        mem_size <= d_size;
        r_starve <= if_req ? r_starve + SW'(1) : '0;
      end
      if (r_state == WAIT && w_lat_done && mem_rw == RW_READ) begin
        if (r_owner == OWN_IF) if_rdata <= mem_rdata;
        else d_rdata <= mem_rdata;
      end
    end
  end
  assign mem_en = r_state == ISSUE;
  assign if_valid = r_state == RESP && r_owner == OWN_IF;
  assign d_valid = r_state == RESP && r_owner == OWN_D;
  assign stall_if = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; instances 0/1/2 run MEM_LAT 1/2/5, instance 1 is fully scored.
module tb_mem_port_arbiter;
  typedef struct {int cyc; logic [7:0] addr; logic rw; logic [1:0] size; logic [31:0] wdata;} iss_t;
  typedef struct {int cyc; logic is_if; logic [31:0] data;} rsp_t;
  logic Clk = 0, Reset = 1;
  logic if_req = 0, d_req = 0, d_rw = 0;
  logic [7:0] if_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic [1:0] d_size = 0;
  logic [31:0] if_rdata [3], d_rdata [3], mem_wdata [3];
  logic if_valid [3], d_valid [3], mem_en [3], mem_rw [3], stall_if [3], stall_mem [3];
  logic [7:0] mem_addr [3];
  logic [1:0] mem_size [3];
  int cyc = 0, tests = 0, fails = 0, t0;
  logic [31:0] exp_d = 0;
  iss_t iq[$];
  rsp_t rq[$];
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic logic [31:0] mdl(logic [7:0] a);
    return a == 8'h10 ? 32'hE3A01005 : {a, ~a, 8'hA5, a ^ 8'h3C};
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : 5;
    logic [32:0] p [L];
    logic [31:0] rd;
    always @(posedge Clk) begin
      if (Reset) for (int i = 0; i < L; i++) p[i] <= '0;
      else begin
        p[0] <= {mem_en[g], mdl(mem_addr[g])};
        for (int i = 1; i < L; i++) p[i] <= p[i-1];
      end
    end
    assign rd = p[L-1][32] ? p[L-1][31:0] : 32'hBAD0BAD0;
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(2)) u (
      .Clk(Clk), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[g]), .if_valid(if_valid[g]),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_rdata(d_rdata[g]), .d_valid(d_valid[g]),
      .mem_en(mem_en[g]), .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_size(mem_size[g]), .mem_rdata(rd), .stall_if(stall_if[g]), .stall_mem(stall_mem[g])
    );
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic to_cyc(int c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic push_iss(int c, logic [7:0] a, logic rw, logic [1:0] sz, logic [31:0] wd);
    iss_t e;
    e.cyc = c; e.addr = a; e.rw = rw; e.size = sz; e.wdata = wd;
    iq.push_back(e);
  endtask
  task automatic push_rsp(int c, logic is_if, logic [31:0] d);
    rsp_t e;
    e.cyc = c; e.is_if = is_if; e.data = d;
    rq.push_back(e);
  endtask
  task automatic mon();
    iss_t ie;
    rsp_t re;
    if (Reset) return;
    if (mem_en[1]) begin
      if (iq.size() == 0) chk("unexpected_issue_addr", {56'd0, mem_addr[1]}, 64'hFFFF);
      else begin
        ie = iq.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
        chk("issue_addr", {56'd0, mem_addr[1]}, {56'd0, ie.addr});
        chk("issue_rw", {63'd0, mem_rw[1]}, {63'd0, ie.rw});
        chk("issue_size", {62'd0, mem_size[1]}, {62'd0, ie.size});
        if (ie.rw) chk("issue_wdata", {32'd0, mem_wdata[1]}, {32'd0, ie.wdata});
      end
    end
    if (if_valid[1] || d_valid[1]) begin
      if (rq.size() == 0) chk("unexpected_valid_cycle", 64'(cyc), 64'hFFFF);
      else begin
        re = rq.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(re.cyc));
        chk("resp_owner", {62'd0, if_valid[1], d_valid[1]}, {62'd0, re.is_if, !re.is_if});
        chk("resp_data", {32'd0, re.is_if ? if_rdata[1] : d_rdata[1]}, {32'd0, re.data});
      end
    end
  endtask
  initial begin
    fork
      forever begin
        @(negedge Clk);
        mon();
      end
    join_none
    to_cyc(3);
    Reset = 0;
    @(negedge Clk);
    chk("rst_mem_en", {63'd0, mem_en[1]}, 0);
    chk("rst_valids", {62'd0, if_valid[1], d_valid[1]}, 0);
    chk("rst_fields", {mem_addr[1], mem_size[1], mem_rw[1], mem_wdata[1]}, 0);
    chk("rst_rdata", {if_rdata[1], d_rdata[1]}, 0);
    // single fetch
    to_cyc(cyc + 1);
    t0 = cyc;
    if_req = 1; if_addr = 8'h10;
    push_iss(t0 + 1, 8'h10, 0, 2'b01, 0);
    push_rsp(t0 + 4, 1, 32'hE3A01005);
    for (int k = 0; k < 5; k++) begin
      to_cyc(t0 + k);
      @(negedge Clk);
      chk($sformatf("fetch_stall_if_c%0d", k), {63'd0, stall_if[1]}, {63'd0, k < 4});
      if (k == 4) if_req = 0;
    end
    // collision: data first, fetch queued behind it
    to_cyc(cyc + 2);
    t0 = cyc;
    if_req = 1; if_addr = 8'h14;
    d_req = 1; d_rw = 0; d_addr = 8'h24; d_size = 2'b00;
    push_iss(t0 + 1, 8'h24, 0, 2'b00, 0);
    push_iss(t0 + 6, 8'h14, 0, 2'b01, 0);
    push_rsp(t0 + 4, 0, mdl(8'h24));
    push_rsp(t0 + 9, 1, mdl(8'h14));
    exp_d = mdl(8'h24);
    to_cyc(t0 + 4);
    @(negedge Clk);
    chk("coll_stall_if_loser", {63'd0, stall_if[1]}, 1);
    chk("coll_stall_mem_done", {63'd0, stall_mem[1]}, 0);
    d_req = 0;
    to_cyc(t0 + 9);
    @(negedge Clk);
    if_req = 0;
    // write leaves d_rdata untouched
    to_cyc(cyc + 2);
    t0 = cyc;
    d_req = 1; d_rw = 1; d_addr = 8'h20; d_wdata = 32'hDEADBEEF; d_size = 2'b01;
    push_iss(t0 + 1, 8'h20, 1, 2'b01, 32'hDEADBEEF);
    push_rsp(t0 + 4, 0, exp_d);
    to_cyc(t0 + 2);
    @(negedge Clk);
    chk("write_stall_mem", {63'd0, stall_mem[1]}, 1);
    to_cyc(t0 + 4);
    @(negedge Clk);
    d_req = 0; d_rw = 0;
    // starvation: D,D,F,D,D,F then a trailing D once fetch drops
    to_cyc(cyc + 2);
    t0 = cyc;
    if_req = 1; if_addr = 8'h30;
    d_req = 1; d_addr = 8'h40; d_size = 2'b10;
    for (int k = 0; k < 7; k++) begin
      logic f;
      f = k == 2 || k == 5;
      push_iss(t0 + 1 + 5 * k, f ? 8'h30 : 8'h40, 0, f ? 2'b01 : 2'b10, 0);
      push_rsp(t0 + 4 + 5 * k, f, f ? mdl(8'h30) : mdl(8'h40));
    end
    exp_d = mdl(8'h40);
    to_cyc(t0 + 29);
    @(negedge Clk);
    if_req = 0;
    to_cyc(t0 + 34);
    @(negedge Clk);
    d_req = 0;
    // reset in the middle of a read
    to_cyc(cyc + 2);
    t0 = cyc;
    d_req = 1; d_addr = 8'h50; d_size = 2'b01;
    push_iss(t0 + 1, 8'h50, 0, 2'b01, 0);
    to_cyc(t0 + 2);
    Reset = 1; d_req = 0;
    to_cyc(t0 + 3);
    Reset = 0;
    @(negedge Clk);
    chk("midrst_mem_en", {63'd0, mem_en[1]}, 0);
    chk("midrst_valids", {62'd0, if_valid[1], d_valid[1]}, 0);
    chk("midrst_fields", {mem_addr[1], mem_size[1], mem_rw[1], mem_wdata[1]}, 0);
    chk("midrst_rdata", {if_rdata[1], d_rdata[1]}, 0);
    to_cyc(t0 + 4);
    t0 = cyc;
    d_req = 1; d_addr = 8'h54;
    push_iss(t0 + 1, 8'h54, 0, 2'b01, 0);
    push_rsp(t0 + 4, 0, mdl(8'h54));
    to_cyc(t0 + 4);
    @(negedge Clk);
    d_req = 0;
    // latency sweep; request withdrawn after grant must still complete
    to_cyc(cyc + 15);
    t0 = cyc;
    if_req = 1; if_addr = 8'h60;
    push_iss(t0 + 1, 8'h60, 0, 2'b01, 0);
    push_rsp(t0 + 4, 1, mdl(8'h60));
    for (int k = 0; k < 9; k++) begin
      to_cyc(t0 + k);
      if (k == 1) if_req = 0;
      @(negedge Clk);
      chk($sformatf("lat1_valid_c%0d", k), {63'd0, if_valid[0]}, {63'd0, k == 3});
      chk($sformatf("lat5_valid_c%0d", k), {63'd0, if_valid[2]}, {63'd0, k == 7});
      if (k == 3) chk("lat1_rdata", {32'd0, if_rdata[0]}, {32'd0, mdl(8'h60)});
      if (k == 7) chk("lat5_rdata", {32'd0, if_rdata[2]}, {32'd0, mdl(8'h60)});
    end
    to_cyc(cyc + 10);
    chk("issue_queue_drained", 64'(iq.size()), 0);
    chk("resp_queue_drained", 64'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
